fsm_ctrl_param: RTL and testbench

//  Parametrised transaction-layer control FSM. Sequences the layer RESET -> INIT -> IDLE/ACTIVE.

---
 rtl/fsm_ctrl_param.sv | 152 +++++++++++++++
 tb/tb_fsm_ctrl_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_ctrl_param.sv
// fsm_ctrl_param: transaction-layer control FSM.
// Sequences RESET -> INIT -> IDLE/ACTIVE. It latches and validates the FIFO
// high/low thresholds, detects global idle across NFIFO FIFOs, and debounces
// the return to IDLE by IDLE_DLY extra all-empty cycles.
// Bad configurations and FIFO faults trap in a sticky ERROR state.
// Every output is a register loaded from the next-state decode, so each
// output changes in the same cycle as estado.
module fsm_ctrl_param #(
  parameter int NFIFO    = 10,
  parameter int UMB_W    = 3,
  parameter int IDLE_DLY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [UMB_W-1:0] umbral_alto,
  input  logic [UMB_W-1:0] umbral_bajo,
  input  logic [NFIFO-1:0] FIFO_empty,
  input  logic [NFIFO-1:0] FIFO_error,
  output logic             idle,
  output logic             active,
  output logic             error,
  output logic [1:0]       error_code,
  output logic [UMB_W-1:0] interno_alto,
  output logic [UMB_W-1:0] interno_bajo,
  output logic [2:0]       estado
);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_CFG  = 2'b01;
  localparam logic [1:0] CODE_FIFO = 2'b10;

  // The idle counter only has to reach IDLE_DLY; it is at least one bit wide.
  localparam int CNT_W = (IDLE_DLY < 1) ? 1 : $clog2(IDLE_DLY + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [2:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       next_state_s;
  logic [CNT_W-1:0] next_cnt_s;
  logic [1:0]       next_code_s;
  logic             latch_s;
  logic             all_empty_s;
  logic             any_err_s;
  logic             cfg_ok_s;

  // Next-state, counter, error-code and threshold-latch decode.
  always_comb begin
    all_empty_s  = &FIFO_empty;
    any_err_s    = |FIFO_error;
    cfg_ok_s     = (umbral_bajo <= umbral_alto);
    next_state_s = state_r;
    next_cnt_s   = '0;
    next_code_s  = CODE_NONE;
    // Thresholds are captured whenever INIT sees a valid pair, including while
    // init is still held high, so a held init keeps reloading them.
    if (state_r == ST_INIT && cfg_ok_s) begin
      latch_s = 1'b1;
    end else begin
      latch_s = 1'b0;
    end

    if (init) begin
      next_state_s = ST_INIT;
    end else begin
      case (state_r)
        ST_RESET: begin
          next_state_s = ST_INIT;
        end
        ST_INIT: begin
          if (cfg_ok_s) begin
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_ERROR;
            next_code_s  = CODE_CFG;
          end
        end
        ST_IDLE: begin
          if (any_err_s) begin
            next_state_s = ST_ERROR;
            next_code_s  = CODE_FIFO;
          end else if (!all_empty_s) begin
            next_state_s = ST_ACTIVE;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (any_err_s) begin
            next_state_s = ST_ERROR;
            next_code_s  = CODE_FIFO;
          end else if (all_empty_s) begin
            if (cnt_r == CNT_MAX) begin
              next_state_s = ST_IDLE;
            end else begin
              next_state_s = ST_ACTIVE;
              next_cnt_s   = cnt_r + CNT_ONE;
            end
          end else begin
            next_state_s = ST_ACTIVE;
          end
        end
        ST_ERROR: begin
          // Sticky: only init or reset leave ERROR, and the code is held.
          next_state_s = ST_ERROR;
          next_code_s  = error_code;
        end
        default: begin
          next_state_s = ST_RESET;
        end
      endcase
    end
  end

  // State, counter and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RESET;
      cnt_r        <= '0;
      idle         <= 1'b0;
      active       <= 1'b0;
      error        <= 1'b0;
      error_code   <= CODE_NONE;
      interno_alto <= '0;
      interno_bajo <= '0;
    end else begin
      state_r    <= next_state_s;
      cnt_r      <= next_cnt_s;
      idle       <= (next_state_s == ST_IDLE);
      active     <= (next_state_s == ST_ACTIVE);
      error      <= (next_state_s == ST_ERROR);
      error_code <= next_code_s;
      if (latch_s) begin
        interno_alto <= umbral_alto;
        interno_bajo <= umbral_bajo;
      end else begin
        interno_alto <= interno_alto;
        interno_bajo <= interno_bajo;
      end
    end
  end

  assign estado = state_r;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Testbench for fsm_ctrl_param (NFIFO=10, UMB_W=3, IDLE_DLY=3).
// A table of per-edge vectors is driven on the falling edge. The expected
// result of each vector goes into a scoreboard queue and is compared after
// the following rising edge. Hand-written sequences cover asynchronous
// reset between edges and recovery from an unused state encoding.
module tb_fsm_ctrl_param;

  localparam int NF  = 10;
  localparam int UW  = 3;
  localparam int DLY = 3;

  localparam logic [NF-1:0] ALL = 10'h3FF;
  localparam logic [NF-1:0] NE4 = 10'h3EF;
  localparam logic [NF-1:0] E9  = 10'h200;
  localparam logic [NF-1:0] NOE = 10'h000;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [UW-1:0] umbral_alto;
  logic [UW-1:0] umbral_bajo;
  logic [NF-1:0] FIFO_empty;
  logic [NF-1:0] FIFO_error;
  logic          idle;
  logic          active;
  logic          error;
  logic [1:0]    error_code;
  logic [UW-1:0] interno_alto;
  logic [UW-1:0] interno_bajo;
  logic [2:0]    estado;

  typedef struct {
    logic          init;
    logic [UW-1:0] alto;
    logic [UW-1:0] bajo;
    logic [NF-1:0] empty;
    logic [NF-1:0] ferr;
    logic [2:0]    st;
    logic [1:0]    code;
    logic [UW-1:0] ia;
    logic [UW-1:0] ib;
  } vec_t;

  typedef struct {
    logic [2:0]    st;
    logic [1:0]    code;
    logic [UW-1:0] ia;
    logic [UW-1:0] ib;
  } exp_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  fsm_ctrl_param #(.NFIFO(NF), .UMB_W(UW), .IDLE_DLY(DLY)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .FIFO_empty(FIFO_empty), .FIFO_error(FIFO_error),
    .idle(idle), .active(active), .error(error), .error_code(error_code),
    .interno_alto(interno_alto), .interno_bajo(interno_bajo), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, " estado"}, 32'(estado), 32'(e.st));
    chk({tag, " idle"}, 32'(idle), 32'(e.st == 3'd2));
    chk({tag, " active"}, 32'(active), 32'(e.st == 3'd3));
    chk({tag, " error"}, 32'(error), 32'(e.st == 3'd4));
    chk({tag, " error_code"}, 32'(error_code), 32'(e.code));
    chk({tag, " interno_alto"}, 32'(interno_alto), 32'(e.ia));
    chk({tag, " interno_bajo"}, 32'(interno_bajo), 32'(e.ib));
  endtask

  function automatic vec_t mk(input logic i, input logic [UW-1:0] a, input logic [UW-1:0] b,
                              input logic [NF-1:0] em, input logic [NF-1:0] fe,
                              input logic [2:0] st, input logic [1:0] code,
                              input logic [UW-1:0] ia, input logic [UW-1:0] ib);
    vec_t v;
    v.init = i; v.alto = a; v.bajo = b; v.empty = em; v.ferr = fe;
    v.st = st; v.code = code; v.ia = ia; v.ib = ib;
    return v;
  endfunction

  // Wait for the rising edge, compare against the scoreboard head, return to the falling edge.
  task automatic edge_and_compare(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk_outputs(tag, e);
    end
    @(negedge clk);
  endtask

  // Drive one vector (called at a falling edge) and score it.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    init        = v.init;
    umbral_alto = v.alto;
    umbral_bajo = v.bajo;
    FIFO_empty  = v.empty;
    FIFO_error  = v.ferr;
    e.st = v.st; e.code = v.code; e.ia = v.ia; e.ib = v.ib;
    sb_q.push_back(e);
    edge_and_compare(tag);
  endtask

  initial begin
    exp_t rst_e;
    exp_t e;
    rst_e.st = 3'd0; rst_e.code = 2'd0; rst_e.ia = 3'd0; rst_e.ib = 3'd0;

    // Release with init=0, 6/2, all FIFOs empty: RESET, INIT, IDLE.
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd1, 2'd0, 3'd0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    // Idle debounce: 4 consecutive all-empty edges are needed.
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, NE4, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    // A glitch after 2 empty edges restarts the count.
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, NE4, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, NE4, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    // ACTIVE with a FIFO fault together with all-empty: ERROR wins and is sticky.
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, NE4, NOE, 3'd3, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, E9,  3'd4, 2'd2, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, NE4, NOE, 3'd4, 2'd2, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd4, 2'd2, 3'd6, 3'd2));
    // init together with a fault: INIT wins, code clears.
    tbl.push_back(mk(1'b1, 3'd6, 3'd2, ALL, E9,  3'd1, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    // Fault seen in IDLE.
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, E9,  3'd4, 2'd2, 3'd6, 3'd2));
    tbl.push_back(mk(1'b1, 3'd6, 3'd2, ALL, NOE, 3'd1, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd6, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd6, 3'd2));
    // Bad configuration (bajo > alto): ERROR 01, thresholds untouched.
    tbl.push_back(mk(1'b1, 3'd3, 3'd5, ALL, NOE, 3'd1, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd3, 3'd5, ALL, NOE, 3'd4, 2'd1, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd3, 3'd5, ALL, NOE, 3'd4, 2'd1, 3'd6, 3'd2));
    tbl.push_back(mk(1'b1, 3'd7, 3'd1, ALL, NOE, 3'd1, 2'd0, 3'd6, 3'd2));
    tbl.push_back(mk(1'b0, 3'd7, 3'd1, ALL, NOE, 3'd2, 2'd0, 3'd7, 3'd1));
    // Held init relatches every cycle; equal thresholds are valid.
    tbl.push_back(mk(1'b1, 3'd5, 3'd5, ALL, NOE, 3'd1, 2'd0, 3'd7, 3'd1));
    tbl.push_back(mk(1'b1, 3'd5, 3'd5, ALL, NOE, 3'd1, 2'd0, 3'd5, 3'd5));
    tbl.push_back(mk(1'b1, 3'd4, 3'd0, ALL, NOE, 3'd1, 2'd0, 3'd4, 3'd0));
    tbl.push_back(mk(1'b0, 3'd4, 3'd0, ALL, NOE, 3'd2, 2'd0, 3'd4, 3'd0));
    // init from ACTIVE, then finish in ACTIVE for the reset test.
    tbl.push_back(mk(1'b0, 3'd4, 3'd0, NE4, NOE, 3'd3, 2'd0, 3'd4, 3'd0));
    tbl.push_back(mk(1'b1, 3'd4, 3'd0, NE4, NOE, 3'd1, 2'd0, 3'd4, 3'd0));
    tbl.push_back(mk(1'b0, 3'd4, 3'd0, ALL, NOE, 3'd2, 2'd0, 3'd4, 3'd0));
    tbl.push_back(mk(1'b0, 3'd4, 3'd0, NE4, NOE, 3'd3, 2'd0, 3'd4, 3'd0));

    // Power-on reset.
    reset = 1'b1; init = 1'b0; umbral_alto = 3'd6; umbral_bajo = 3'd2;
    FIFO_empty = ALL; FIFO_error = NOE;
    #1 reset = 1'b0;
    #1 chk_outputs("por", rst_e);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset asserted between edges while ACTIVE: outputs clear with no clock edge.
    #3 reset = 1'b0;
    #1 chk_outputs("async_rst", rst_e);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1'b0, 3'd2, 3'd2, ALL, NOE, 3'd1, 2'd0, 3'd0, 3'd0), "post_rst0");
    apply(mk(1'b0, 3'd2, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd2, 3'd2), "post_rst1");

    // Unused encoding 6 returns to RESET on the next edge.
    force dut.state_r = 3'd6;
    #1 release dut.state_r;
    #1 chk("illegal forced", 32'(estado), 32'd6);
    e.st = 3'd0; e.code = 2'd0; e.ia = 3'd2; e.ib = 3'd2;
    sb_q.push_back(e);
    edge_and_compare("illegal_recover");
    apply(mk(1'b0, 3'd2, 3'd2, ALL, NOE, 3'd1, 2'd0, 3'd2, 3'd2), "illegal_init");
    apply(mk(1'b0, 3'd2, 3'd2, ALL, NOE, 3'd2, 2'd0, 3'd2, 3'd2), "illegal_idle");

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
